// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, fetches over req/ack,
// and stalls the downstream control unit via en.
module fetch_unit #(
  parameter logic [7:0]  RESET_PC       = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_pc,
  input  logic        pc_src,
  input  logic [7:0]  jump_addr,
  input  logic        halted,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic [7:0]  pc_out,
  output logic        en,
  output logic        fault,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FETCH_WAIT = 2'd1,
    STOPPED    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        stale_q, stale_d;
  logic        fault_q, fault_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] to_q, to_d;
  logic        to_hit;

  // the request that is missing its ack now would be the last allowed one
  assign to_hit = (TIMEOUT_CYCLES != 32'd0) &&
                  ((to_q + 32'd1) >= TIMEOUT_CYCLES);

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      stale_q <= 1'b1;
      fault_q <= 1'b0;
      cnt_q   <= 16'h0000;
      to_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      stale_q <= stale_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // next state and datapath updates; halted always wins
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    stale_d = stale_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    unique case (state_q)
      RUN: begin
        if (halted) begin
          state_d = STOPPED;
        end else if (en && pc_src) begin
          pc_d    = jump_addr;
          stale_d = 1'b1;
        end else if (en && inc_pc) begin
          pc_d    = pc_q + 8'd1;
          stale_d = 1'b1;
          cnt_d   = cnt_q + 16'd1;
        end else if (inc_pc && stale_q) begin
          state_d = FETCH_WAIT;
          to_d    = 32'd0;
        end
      end
      FETCH_WAIT: begin
        if (halted) begin
          state_d = STOPPED;
        end else if (imem_ack) begin
          ir_d    = imem_rdata;
          stale_d = 1'b0;
          to_d    = 32'd0;
          state_d = RUN;
        end else if (to_hit) begin
          fault_d = 1'b1;
          state_d = STOPPED;
        end else begin
          to_d = to_q + 32'd1;
        end
      end
      STOPPED: begin
        state_d = STOPPED;
      end
      default: begin
        state_d = STOPPED;
      end
    endcase
  end

  // handshake and stall outputs; en never depends on imem_ack
  always_comb begin
    en       = (state_q == RUN) && !(inc_pc && stale_q) &&
               !halted && !fault_q;
    imem_req = (state_q == FETCH_WAIT);
  end

  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instruction = ir_q;
  assign fault       = fault_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model
// of PC/IR/fetch behaviour with a variable-latency memory.
module tb_fetch_unit;

  localparam logic [7:0] RPC = 8'h00;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        inc_pc, pc_src, halted;
  logic [7:0]  jump_addr;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic [7:0]  pc_out;
  logic        en, fault;
  logic [15:0] instr_count;

  fetch_unit #(.RESET_PC(RPC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .inc_pc(inc_pc), .pc_src(pc_src),
    .jump_addr(jump_addr), .halted(halted),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_out(pc_out),
    .en(en), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  logic [15:0] mem [256];
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_cnt;
  bit          m_fresh, m_stop, m_fault, m_wait;
  int          m_age, lat, req_idx, stop_cnt;

  function automatic bit m_en();
    return !m_stop && !m_wait && !m_fault && !halted &&
           !(inc_pc && !m_fresh);
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_ir = 16'h0; m_cnt = 16'h0;
    m_fresh = 0; m_stop = 0; m_fault = 0;
    m_wait = 0; m_age = 0; req_idx = 0; lat = 0;
  endtask

  task automatic pick_lat();
    int r;
    r = $urandom_range(0, 11);
    if (r <= 3) lat = r;
    else if (r == 4) lat = 15;
    else if (r == 5) lat = 16;
    else if (r == 6) lat = 255;
    else lat = r & 1;
  endtask

  task automatic check_outs();
    chk("en", en, m_en());
    chk("req", imem_req, m_wait);
    chk("addr", imem_addr, m_pc);
    chk("ir", instruction, m_ir);
    chk("pc", pc_out, m_pc);
    chk("fault", fault, m_fault);
    chk("count", instr_count, m_cnt);
  endtask

  task automatic model_step();
    bit e;
    e = m_en();
    if (m_stop) begin
    end else if (halted) begin
      m_stop = 1; m_wait = 0;
    end else if (m_wait) begin
      if (imem_ack) begin
        m_ir = imem_rdata; m_fresh = 1;
        m_wait = 0; m_age = 0;
      end else begin
        m_age++; req_idx++;
        if (TO > 0 && m_age == TO) begin
          m_fault = 1; m_stop = 1; m_wait = 0;
        end
      end
    end else if (e && pc_src) begin
      m_pc = jump_addr; m_fresh = 0;
    end else if (e && inc_pc) begin
      m_pc = m_pc + 8'd1; m_fresh = 0; m_cnt = m_cnt + 16'd1;
    end else if (inc_pc && !m_fresh) begin
      m_wait = 1; m_age = 0; req_idx = 0; pick_lat();
    end
  endtask

  task automatic drive_inputs();
    int r;
    inc_pc = ($urandom_range(0, 3) != 0);
    pc_src = ($urandom_range(0, 7) == 0);
    halted = ($urandom_range(0, 299) == 0);
    r = $urandom_range(0, 3);
    if (r == 0) jump_addr = 8'hFF;
    else if (r == 1) jump_addr = 8'hFE;
    else jump_addr = 8'($urandom);
    if (m_wait) imem_ack = (req_idx == lat);
    else imem_ack = ($urandom_range(0, 7) == 0);
    if (m_wait && imem_ack) imem_rdata = mem[m_pc];
    else imem_rdata = 16'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;
    reset = 1'b1;
    inc_pc = 0; pc_src = 0; halted = 0; jump_addr = 8'h0;
    imem_ack = 0; imem_rdata = 16'h0;
    model_reset();
    stop_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_outs();
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      reset = 1'b0;
      drive_inputs();
      #1 check_outs();
      if (m_stop) stop_cnt++;
      else stop_cnt = 0;
      if (stop_cnt > 4 || $urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_pc", pc_out, RPC);
        chk("rst_ir", instruction, 0);
        chk("rst_fault", fault, 0);
        chk("rst_cnt", instr_count, 0);
        model_reset();
        stop_cnt = 0;
        @(posedge clk);
        continue;
      end
      @(posedge clk);
      model_step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the multi-cycle control unit. It owns the 8-bit program counter and the instruction register, and fetches 16-bit instruction words from instruction memory over a req/ack handshake. It drives the control unit's en stall line and feeds it instruction and pc_in. It applies the control unit's inc_PC, pc_src and jump_addr requests, and stops on HALT or on a memory timeout.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.
TIMEOUT_CYCLES, 16, number of req cycles without ack before fault; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
inc_pc  in  1  from control unit; it is in FETCH and requests PC+1.
pc_src  in  1  from control unit; load PC from jump_addr.
jump_addr  in  8  from control unit; branch or jump target.
halted  in  1  from control unit; sticky HALT indication.
imem_req  out  1  instruction memory read request.
imem_addr  out  8  read address; equals pc while imem_req is high.
imem_ack  in  1  memory response valid; imem_rdata is valid in the same cycle.
imem_rdata  in  16  instruction word.
instruction  out  16  instruction register (IR), to control unit.
pc_out  out  8  current PC, to control unit pc_in.
en  out  1  control unit enable (stall when 0).
fault  out  1  sticky; fetch timed out.
instr_count  out  16  count of accepted fetches; wraps at 16'hFFFF.

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-request.
  - pc=RESET_PC, instruction=16'h0000, ir_stale=1, state=RUN.
  - imem_req=0, imem_addr=RESET_PC, fault=0, instr_count=0, timeout counter=0.
- States:
  - RUN: IR is fresh, or no fetch is needed.
  - FETCH_WAIT: request outstanding.
  - STOPPED: halted or faulted; terminal until reset.
- en is combinational: en = (state==RUN) & ~(inc_pc & ir_stale) & ~halted & ~fault.
  - It has no combinational path from imem_ack.
- RUN with inc_pc=1 and ir_stale=1 → FETCH_WAIT.
  - en=0 in that cycle.
  - imem_req goes high from the next cycle, with imem_addr=pc.
- FETCH_WAIT:
  - imem_req=1, imem_addr=pc, both held stable until ack.
  - On imem_ack=1: IR<=imem_rdata, ir_stale<=0, imem_req<=0, go to RUN.
  - imem_ack while imem_req=0 is ignored.
- Accepted increment: en=1 and inc_pc=1 (RUN, IR fresh).
  - pc<=pc+1 (8-bit wrap, 8'hFF→8'h00), ir_stale<=1, instr_count<=instr_count+1.
  - IR is unchanged, so the control unit's DECODE cycle sees the fetched word and pc_out = fetched address + 1.
- Accepted redirect: en=1 and pc_src=1.
  - pc<=jump_addr, ir_stale<=1.
  - If pc_src and inc_pc are both high, pc_src wins: no increment and no count.
- inc_pc and pc_src are ignored while en=0.
- Minimum fetch latency: 1 request cycle when memory acks in the same cycle as req.
  - FETCH-state stall = 2 cycles (decision cycle + request cycle) before en rises.
- Timeout (TIMEOUT_CYCLES>0):
  - A counter increments on each FETCH_WAIT cycle without ack.
  - On reaching TIMEOUT_CYCLES: fault<=1, imem_req<=0, go to STOPPED.
  - An ack arriving in the same cycle as the threshold wins; the fetch completes and there is no fault.
  - The counter clears on ack.
- halted=1 in any state → STOPPED next cycle.
  - An outstanding request is dropped: imem_req=0 and a late ack is ignored.
  - pc, IR and instr_count freeze.
- STOPPED: en=0, imem_req=0. Exits only via reset.

Test Plan:
- Reset, memory acks 1 cycle after req with rdata=16'h1234 at addr 0 → imem_req rises, addr=8'h00; IR=16'h1234; en rises; on inc_pc accept pc=8'h01, instr_count=1.
- Memory with 3-cycle ack latency → imem_req and imem_addr held stable for 3 cycles; en=0 throughout; IR loads only on the ack cycle.
- pc=8'h05, pc_src=1, jump_addr=8'h40 with en=1 → pc=8'h40; next inc_pc triggers fetch at addr 8'h40; instr_count unchanged by the redirect.
- pc=8'hFF accepted inc_pc → pc=8'h00. Simultaneous pc_src=1, inc_pc=1, jump_addr=8'h10 → pc=8'h10, count unchanged.
- TIMEOUT_CYCLES=16, no ack → fault=1 after 16 req cycles; imem_req=0; en=0; a later ack is ignored. Ack on exactly cycle 16 → no fault.
- halted asserted mid-fetch → imem_req drops next cycle, en stays 0. Async reset mid-request → imem_req=0 immediately, pc=RESET_PC, normal fetch resumes after release.
